tl_mux_protocol_monitor: RTL

TL_MUX_PROTOCOL_MONITOR -- requirements
Module: tl_mux_protocol_monitor

---
 rtl/tl_mux_protocol_monitor_if.sv | 29 ++
 rtl/tl_mux_protocol_monitor.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/tl_mux_protocol_monitor_if.sv
// Multiplexed TileLink-UL A/D channel bundle: one slice per upstream port.
interface tl_mux_protocol_monitor_if #(
  parameter int NSRC   = 2,
  parameter int SRC_W  = 4,
  parameter int ADDR_W = 32,
  parameter int SIZE_W = 3
);
  logic [NSRC-1:0]        a_valid;
  logic [NSRC-1:0]        a_ready;
  logic [3*NSRC-1:0]      a_opcode;
  logic [SIZE_W*NSRC-1:0] a_size;
  logic [SRC_W*NSRC-1:0]  a_source;
  logic [ADDR_W*NSRC-1:0] a_address;
  logic [NSRC-1:0]        d_valid;
  logic [NSRC-1:0]        d_ready;
  logic [3*NSRC-1:0]      d_opcode;
  logic [SIZE_W*NSRC-1:0] d_size;
  logic [SRC_W*NSRC-1:0]  d_source;

  modport master (
    output a_valid, a_ready, a_opcode, a_size, a_source, a_address,
    output d_valid, d_ready, d_opcode, d_size, d_source
  );

  modport slave (
    input a_valid, a_ready, a_opcode, a_size, a_source, a_address,
    input d_valid, d_ready, d_opcode, d_size, d_source
  );
endinterface

// File: rtl/tl_mux_protocol_monitor.sv
// Passive TileLink-UL protocol checker on one of NSRC multiplexed ports:
// tracks outstanding sources and raises sticky error flags on violations.
module tl_mux_protocol_monitor #(
  parameter  int NSRC    = 2,
  parameter  int SRC_W   = 4,
  parameter  int ADDR_W  = 32,
  parameter  int SIZE_W  = 3,
  parameter  int BEAT_LG = 2,
  localparam int SEL_W   = (NSRC > 1) ? $clog2(NSRC) : 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    err_clear,
  tl_mux_protocol_monitor_if.slave bus,
  output logic [5:0]              err_flags,
  output logic                    err_pulse,
  output logic [SRC_W:0]          inflight_cnt,
  output logic                    idle
);
  localparam int NENT  = 1 << SRC_W;
  localparam int CNT_W = 1 << SIZE_W;

  function automatic logic [CNT_W-1:0] last_beat(input logic [SIZE_W-1:0] size,
                                                 input logic has_data);
    logic [CNT_W-1:0] n;
    n = '0;
    if (has_data && (int'(size) > BEAT_LG))
      n = CNT_W'((1 << (int'(size) - BEAT_LG)) - 1);
    return n;
  endfunction

  function automatic logic misaligned(input logic [ADDR_W-1:0] addr,
                                      input logic [SIZE_W-1:0] size);
    logic [ADDR_W-1:0] mask;
    mask = ~({ADDR_W{1'b1}} << size);
    return (addr & mask) != '0;
  endfunction

  function automatic logic legal_a_op(input logic [2:0] op);
    return (op == 3'd0) || (op == 3'd1) || (op == 3'd4);
  endfunction

  function automatic logic [SRC_W:0] popcount(input logic [NENT-1:0] v);
    logic [SRC_W:0] c;
    c = '0;
    for (int i = 0; i < NENT; i++) c = c + {{SRC_W{1'b0}}, v[i]};
    return c;
  endfunction

  // Stage p0: the selected port's channels
  logic              a_valid_p0, a_ready_p0, d_valid_p0, d_ready_p0;
  logic [2:0]        a_opcode_p0, d_opcode_p0;
  logic [SIZE_W-1:0] a_size_p0, d_size_p0;
  logic [SRC_W-1:0]  a_source_p0, d_source_p0;
  logic [ADDR_W-1:0] a_address_p0;

  always_comb begin
    a_valid_p0   = 1'b0;
    a_ready_p0   = 1'b0;
    a_opcode_p0  = '0;
    a_size_p0    = '0;
    a_source_p0  = '0;
    a_address_p0 = '0;
    d_valid_p0   = 1'b0;
    d_ready_p0   = 1'b0;
    d_opcode_p0  = '0;
    d_size_p0    = '0;
    d_source_p0  = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (int'(sel) == i) begin
        a_valid_p0   = bus.a_valid[i];
        a_ready_p0   = bus.a_ready[i];
        a_opcode_p0  = bus.a_opcode[i*3 +: 3];
        a_size_p0    = bus.a_size[i*SIZE_W +: SIZE_W];
        a_source_p0  = bus.a_source[i*SRC_W +: SRC_W];
        a_address_p0 = bus.a_address[i*ADDR_W +: ADDR_W];
        d_valid_p0   = bus.d_valid[i];
        d_ready_p0   = bus.d_ready[i];
        d_opcode_p0  = bus.d_opcode[i*3 +: 3];
        d_size_p0    = bus.d_size[i*SIZE_W +: SIZE_W];
        d_source_p0  = bus.d_source[i*SRC_W +: SRC_W];
      end
    end
  end

  // Stage p1: registered tracker, beat counters and stall capture
  logic [CNT_W-1:0]  a_cnt, d_cnt;
  logic [NENT-1:0]   inflight, inflight_nxt, rec_get;
  logic [SIZE_W-1:0] rec_size [NENT];
  logic [2:0]        a_hdr_opcode, d_hdr_opcode;
  logic [SIZE_W-1:0] a_hdr_size, d_hdr_size;
  logic [SRC_W-1:0]  a_hdr_source, d_hdr_source;
  logic              a_stall_p1;
  logic [2:0]        a_opcode_p1;
  logic [SIZE_W-1:0] a_size_p1;
  logic [SRC_W-1:0]  a_source_p1;
  logic [ADDR_W-1:0] a_address_p1;
  logic [SEL_W-1:0]  sel_p1;

  logic       a_fire, d_fire, a_first, a_last, d_first, d_last, a_open, d_close;
  logic [5:0] err_now;

  always_comb begin
    a_fire  = a_valid_p0 & a_ready_p0;
    d_fire  = d_valid_p0 & d_ready_p0;
    a_first = (a_cnt == '0);
    d_first = (d_cnt == '0);
    a_last  = (a_cnt == last_beat(a_size_p0, (a_opcode_p0 == 3'd0) || (a_opcode_p0 == 3'd1)));
    d_last  = (d_cnt == last_beat(d_size_p0, d_opcode_p0 == 3'd1));
    a_open  = a_fire & a_first;
    d_close = d_fire & d_last;

    // A response closing a source may be immediately followed by its reuse.
    inflight_nxt = inflight;
    if (d_close) inflight_nxt[d_source_p0] = 1'b0;
    if (a_open)  inflight_nxt[a_source_p0] = 1'b1;

    err_now = '0;
    if (a_stall_p1 && (!a_valid_p0 || (a_opcode_p0 != a_opcode_p1) ||
        (a_size_p0 != a_size_p1) || (a_source_p0 != a_source_p1) ||
        (a_address_p0 != a_address_p1)))
      err_now[0] = 1'b1;
    if (a_open && inflight[a_source_p0] && !(d_close && (d_source_p0 == a_source_p0)))
      err_now[1] = 1'b1;
    if (d_fire && !inflight[d_source_p0])
      err_now[2] = 1'b1;
    if (d_fire && inflight[d_source_p0] &&
        ((d_opcode_p0 != {2'b00, rec_get[d_source_p0]}) ||
         (d_size_p0 != rec_size[d_source_p0])))
      err_now[3] = 1'b1;
    if (a_fire && !a_first && ((a_opcode_p0 != a_hdr_opcode) ||
        (a_size_p0 != a_hdr_size) || (a_source_p0 != a_hdr_source)))
      err_now[3] = 1'b1;
    if (d_fire && !d_first && ((d_opcode_p0 != d_hdr_opcode) ||
        (d_size_p0 != d_hdr_size) || (d_source_p0 != d_hdr_source)))
      err_now[3] = 1'b1;
    if (a_fire && (!legal_a_op(a_opcode_p0) || misaligned(a_address_p0, a_size_p0)))
      err_now[4] = 1'b1;
    if ((sel != sel_p1) && !idle)
      err_now[5] = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      inflight     <= '0;
      inflight_cnt <= '0;
      a_cnt        <= '0;
      d_cnt        <= '0;
      a_stall_p1   <= 1'b0;
      err_flags    <= '0;
      err_pulse    <= 1'b0;
    end else begin
      inflight     <= inflight_nxt;
      inflight_cnt <= popcount(inflight_nxt);
      if (a_fire) a_cnt <= a_last ? '0 : a_cnt + 1'b1;
      if (d_fire) d_cnt <= d_last ? '0 : d_cnt + 1'b1;
      a_stall_p1   <= a_valid_p0 & ~a_ready_p0;
      err_flags    <= (err_clear ? 6'h00 : err_flags) | err_now;
      err_pulse    <= |err_now;
    end
  end

  // Payload captures carry no reset; they are only read under a qualifying control bit.
  always_ff @(posedge clock) begin
    sel_p1       <= sel;
    a_opcode_p1  <= a_opcode_p0;
    a_size_p1    <= a_size_p0;
    a_source_p1  <= a_source_p0;
    a_address_p1 <= a_address_p0;
    if (a_open) begin
      rec_get[a_source_p0]  <= (a_opcode_p0 == 3'd4);
      rec_size[a_source_p0] <= a_size_p0;
      a_hdr_opcode          <= a_opcode_p0;
      a_hdr_size            <= a_size_p0;
      a_hdr_source          <= a_source_p0;
    end
    if (d_fire && d_first) begin
      d_hdr_opcode <= d_opcode_p0;
      d_hdr_size   <= d_size_p0;
      d_hdr_source <= d_source_p0;
    end
  end

  always_comb idle = (inflight_cnt == '0) && (a_cnt == '0) && (d_cnt == '0);

endmodule
